uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequencing and buffering controller for the 8-bit UART receiver core (uart_rx).
//  Generates the 16x-oversampling s_tick from a run-time-programmable divisor.
//  Synchronises the raw rx pin before it reaches the core.
//  Captures each rx_done_tick byte plus a framing-error flag into a FIFO.
//  Presents buffered bytes to the CPU/bus side over a valid/ready stream and flags overruns.
// PARAMETERS
//  DIV_W    16  width of the baud divisor register
//  DIV_RST  26  divisor reset value (N-1); 50 MHz / (16*115200) -> 26
//  FIFO_AW  4   FIFO address width; depth = 2**FIFO_AW = 16 entries
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        asynchronous, active-low reset
//  en           in   1        receiver enable
//  div_load     in   1        one-cycle strobe: load div_value
//  div_value    in   DIV_W    new divisor (N-1); s_tick period = div_value+1 clocks
//  rx_in        in   1        raw serial pin (asynchronous)
//  rx_sync      out  1        synchronised rx; drives uart_rx.rx
//  s_tick       out  1        oversample tick; drives uart_rx.s_tick
//  core_reset   out  1        active-high sync reset for uart_rx
//  rx_done_tick in   1        from uart_rx: byte complete
//  rx_dout      in   8        from uart_rx: received byte
//  m_data       out  8        head-of-FIFO byte
//  m_ferr       out  1        head-of-FIFO framing-error flag
//  m_valid      out  1        FIFO non-empty
//  m_ready      in   1        consumer accepts; pop on m_valid & m_ready
//  level        out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW
//  overrun      out  1        sticky: a byte was dropped because the FIFO was full
//  clr_overrun  in   1        one-cycle strobe: clear overrun
// BEHAVIOUR
//  Reset values:
//   - All outputs 0 except rx_sync=1 and core_reset=1.
//   - div_reg=DIV_RST; tick counter 0; FIFO empty.
//  Synchroniser:
//   - 2-flop chain, both flops reset to 1 (idle line).
//   - When en=0, rx_sync is forced to 1.
//  Tick generator:
//   - cnt counts 0..div_reg; s_tick=1 for exactly one cycle when cnt==div_reg, then cnt wraps to 0.
//   - div_reg=0 gives s_tick every cycle.
//   - div_load: div_reg<=div_value and cnt<=0 on the same edge. The first tick occurs div_value+1 cycles later.
//   - When en=0: cnt held at 0 and s_tick=0.
//  core_reset:
//   - Registered; equals ~en delayed one cycle.
//   - It is also asserted for one cycle after any div_load, which aborts a frame in progress. The core must never see a divisor change mid-frame.
//   - After reset_n deassertion, core_reset stays high until en has been sampled high.
//  Capture:
//   - A push occurs on rx_done_tick & en & ~core_reset.
//   - The pushed entry is {ferr, rx_dout}, where ferr = ~rx_sync sampled in the same cycle (uart_rx signals done mid-stop-bit).
//  FIFO:
//   - Registered output, no fall-through: a push into an empty FIFO gives m_valid=1 on the next cycle.
//   - m_data/m_ferr are stable while m_valid & ~m_ready.
//   - Pointers are FIFO_AW bits and wrap modulo depth; level is tracked separately.
//   - Full and push without pop: the byte is dropped, overrun<=1, and level is unchanged.
//   - Full with push and pop in the same cycle: both succeed; level stays at max; no overrun.
//   - Empty with push and pop in the same cycle: pop is ignored because m_valid=0; level becomes 1.
//  overrun:
//   - Cleared only by clr_overrun.
//   - If a drop and clr_overrun occur in the same cycle, the set wins.
//  en deassertion:
//   - Existing FIFO contents stay readable; no new pushes.
//  reset_n mid-operation:
//   - Immediate, asynchronous return to reset values; any frame and FIFO contents are lost.
// STRUCTURE
//  - Package uart_pkg:
//    - UART_DBIT=8;
//    - rx_entry_t = struct {logic ferr; logic [7:0] data;};
//    - localparam for DIV_RST defaults per supported baud rate.
//  - Sub-module uart_rx_fifo: sync FIFO of rx_entry_t with push/pop/full/empty/level and a parameterised depth.
//  - The top level holds the synchroniser, tick generator, core_reset logic, capture and overrun.
//  - uart_rx is instantiated beside this block, not inside it.
// TESTING
//  1. div_load with div_value=3, en=1 -> s_tick pulses every 4 clocks. First pulse on the 4th cycle after the load. core_reset high for 1 cycle.
//  2. With uart_rx attached, div=0, send 0xA5 with a valid stop bit -> one push. m_valid rises the cycle after rx_done_tick; m_data=0xA5, m_ferr=0.
//  3. Send 0x3C with the stop bit driven 0 -> entry m_data=0x3C, m_ferr=1.
//  4. m_ready=0; inject 17 rx_done_ticks with data 0..16 -> level=16, overrun=1.
//     Draining yields 0..15 in order; byte 16 is absent.
//     Then assert clr_overrun together with another drop -> overrun stays 1.
//  5. FIFO full and m_ready=1 with rx_done_tick in the same cycle -> level stays 16, overrun stays 0, and the new byte appears last.
//  6. Assert reset_n=0 mid-frame with level=5 -> asynchronously level=0, m_valid=0, rx_sync=1, core_reset=1.
//     After reset_n=1 and en=1, the next clean byte is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int UART_DBIT = 8;

  // One buffered receive result: framing-error flag above the data byte.
  typedef struct packed {
    logic                 ferr;
    logic [UART_DBIT-1:0] data;
  } rx_entry_t;

  localparam int CLK_HZ = 50_000_000;

  // Divisor (N-1) for 16x oversampling, rounded to the nearest whole N.
  function automatic int div_for_baud(input int clk_hz, input int baud);
    return (clk_hz + 8 * baud) / (16 * baud) - 1;
  endfunction

  localparam int DIV_9600   = div_for_baud(CLK_HZ, 9600);    // 325
  localparam int DIV_19200  = div_for_baud(CLK_HZ, 19200);   // 162
  localparam int DIV_57600  = div_for_baud(CLK_HZ, 57600);   // 53
  localparam int DIV_115200 = div_for_baud(CLK_HZ, 115200);  // 26

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO of receive entries. The head entry is read straight from
// registered storage, so a push into an empty FIFO shows up one cycle later.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  rx_entry_t  push_data,
  input  logic       pop,
  output rx_entry_t  pop_data,
  output logic       full,
  output logic       empty,
  output logic [AW:0] level
);

  localparam int DEPTH = 2 ** AW;

  rx_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);

  // Storage write.
  // NOTE: the memory has no reset; only pointers and level are reset, and
  // the head is masked while empty so stale contents never reach the port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencing and buffering controller for the 8-bit UART receiver core:
// rx synchroniser, 16x tick generator, core reset, byte capture, FIFO and
// overrun flag. The uart_rx core itself sits beside this block.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DIV_RST = DIV_115200,
  parameter int FIFO_AW = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 div_load,
  input  logic [DIV_W-1:0]     div_value,
  input  logic                 rx_in,
  output logic                 rx_sync,
  output logic                 s_tick,
  output logic                 core_reset,
  input  logic                 rx_done_tick,
  input  logic [UART_DBIT-1:0] rx_dout,
  output logic [UART_DBIT-1:0] m_data,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [FIFO_AW:0]     level,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  logic             sync_q1;
  logic             sync_q2;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;
  logic             cnt_wrap;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  rx_entry_t        push_entry;
  rx_entry_t        head;

  // Two-flop synchroniser; both stages reset to the idle-high line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= rx_in;
      sync_q2 <= sync_q1;
    end
  end

  assign rx_sync = sync_q2 | ~en;

  assign cnt_wrap = (cnt == div_reg);
  assign s_tick   = en & cnt_wrap;

  // Tick counter runs 0..div_reg; a divisor load restarts it from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg <= DIV_W'(DIV_RST);
      cnt     <= '0;
    end else if (div_load) begin
      div_reg <= div_value;
      cnt     <= '0;
    end else if (!en || cnt_wrap) begin
      cnt     <= '0;
    end else begin
      cnt     <= cnt + DIV_W'(1);
    end
  end

  // Core held in reset while disabled and for one cycle after a divisor
  // change, so a frame never straddles two baud rates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) core_reset <= 1'b1;
    else          core_reset <= ~en | div_load;
  end

  // uart_rx raises done mid-stop-bit, so the live line level is the stop bit.
  assign push       = rx_done_tick & en & ~core_reset;
  assign push_entry = '{ferr: ~rx_sync, data: rx_dout};
  assign pop        = m_valid & m_ready;
  assign drop       = push & fifo_full & ~pop;

  uart_rx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = head.data;
  assign m_ferr  = head.ferr;

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a queue-based FIFO model predicts
// accepted entries into a scoreboard that a negedge monitor drains.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DIV_W   = 16;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              en = 1'b0;
  logic              div_load = 1'b0;
  logic [DIV_W-1:0]  div_value = '0;
  logic              rx_in = 1'b1;
  logic              rx_done_tick = 1'b0;
  logic [7:0]        rx_dout = '0;
  logic              m_ready = 1'b0;
  logic              clr_overrun = 1'b0;
  logic              rx_sync;
  logic              s_tick;
  logic              core_reset;
  logic [7:0]        m_data;
  logic              m_ferr;
  logic              m_valid;
  logic [FIFO_AW:0]  level;
  logic              overrun;

  uart_rx_ctrl #(
    .DIV_W   (DIV_W),
    .DIV_RST (26),
    .FIFO_AW (FIFO_AW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .div_load     (div_load),
    .div_value    (div_value),
    .rx_in        (rx_in),
    .rx_sync      (rx_sync),
    .s_tick       (s_tick),
    .core_reset   (core_reset),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .m_data       (m_data),
    .m_ferr       (m_ferr),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: FIFO contents, scoreboard of entries still to be read,
  // overrun flag, core-reset level, and the rx_in history seen by rx_sync.
  logic [8:0] model_q [$];
  logic [8:0] sb_q [$];
  bit         ov_model = 1'b0;
  bit         cr_model = 1'b1;
  bit         h1 = 1'b1;
  bit         h2 = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; starts just after a rising edge and ends
  // 1 time unit after the next one, with model updated and state checked.
  task automatic step(input bit done, input logic [7:0] d, input bit rxv,
                      input bit rdy, input bit clr);
    bit exp_sync;
    bit pop;
    bit acc;
    bit drop;
    rx_done_tick = done;
    rx_dout      = d;
    rx_in        = rxv;
    m_ready      = rdy;
    clr_overrun  = clr;
    exp_sync = en ? h2 : 1'b1;
    h2 = h1;
    h1 = rxv;
    pop  = rdy && (model_q.size() > 0);
    acc  = 1'b0;
    drop = 1'b0;
    if (done && en && !cr_model) begin
      if (model_q.size() < DEPTH || pop) acc = 1'b1;
      else drop = 1'b1;
    end
    @(posedge clk);
    #1;
    cr_model = !en || div_load;
    div_load = 1'b0;
    if (pop) void'(model_q.pop_front());
    if (acc) begin
      model_q.push_back({~exp_sync, d});
      sb_q.push_back({~exp_sync, d});
    end
    if (drop)     ov_model = 1'b1;
    else if (clr) ov_model = 1'b0;
    check("level", 32'(level), 32'(model_q.size()));
    check("m_valid", 32'(m_valid), 32'(model_q.size() > 0));
    check("overrun", 32'(overrun), 32'(ov_model));
  endtask

  task automatic idle(input int n, input bit rdy, input bit rxv);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, rxv, rdy, 1'b0);
  endtask

  // Monitor: every accepted transfer must match the oldest predicted entry.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (reset_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got data 0x%0h, expected no entry", m_data);
      end else begin
        exp = sb_q.pop_front();
        check("m_data", 32'(m_data), 32'(exp[7:0]));
        check("m_ferr", 32'(m_ferr), 32'(exp[8]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("rst_rx_sync", 32'(rx_sync), 32'd1);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_s_tick", 32'(s_tick), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_ferr", 32'(m_ferr), 32'd0);
    reset_n = 1'b1;

    // core_reset stays high until en is sampled high
    idle(2, 1'b0, 1'b1);
    check("cr_before_en", 32'(core_reset), 32'd1);
    en = 1'b1;
    idle(2, 1'b0, 1'b1);
    check("cr_after_en", 32'(core_reset), 32'd0);

    // Divisor 3: tick every 4 clocks, first on the 4th cycle after load
    div_value = 16'd3;
    div_load  = 1'b1;
    idle(1, 1'b0, 1'b1);
    check("load_core_reset", 32'(core_reset), 32'd1);
    check("div3_tick_c1", 32'(s_tick), 32'd0);
    for (int j = 2; j <= 12; j++) begin
      idle(1, 1'b0, 1'b1);
      check($sformatf("div3_tick_c%0d", j), 32'(s_tick), 32'((j % 4) == 0));
      if (j == 2) check("load_cr_release", 32'(core_reset), 32'd0);
    end

    // Divisor 0: tick every cycle; disabled receiver gates it off
    div_value = 16'd0;
    div_load  = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      idle(1, 1'b0, 1'b1);
      check($sformatf("div0_tick_c%0d", j), 32'(s_tick), 32'd1);
    end
    en = 1'b0;
    rx_in = 1'b0;
    #1;
    check("dis_s_tick", 32'(s_tick), 32'd0);
    check("dis_rx_sync", 32'(rx_sync), 32'd1);
    idle(3, 1'b0, 1'b0);
    check("dis_core_reset", 32'(core_reset), 32'd1);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);   // ignored while disabled
    en = 1'b1;
    idle(3, 1'b0, 1'b1);

    // Clean byte 0xA5, then 0x3C with a low stop bit
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b1);
    idle(3, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1, 1'b1);
    check("sb_drained_1", 32'(sb_q.size()), 32'd0);

    // Overrun: 17 bytes into a 16-deep FIFO, then a drop racing a clear
    for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    check("full_level", 32'(level), 32'd16);
    check("full_overrun", 32'(overrun), 32'd1);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    check("drop_beats_clr", 32'(overrun), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("clr_overrun", 32'(overrun), 32'd0);
    idle(18, 1'b1, 1'b1);
    check("sb_drained_2", 32'(sb_q.size()), 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    check("full_pushpop_level", 32'(level), 32'd16);
    check("full_pushpop_ovr", 32'(overrun), 32'd0);
    idle(18, 1'b1, 1'b1);
    check("sb_drained_3", 32'(sb_q.size()), 32'd0);

    // Randomised traffic with occasional disable and overrun clears
    for (int i = 0; i < 500; i++) begin
      en = ($urandom_range(0, 19) != 0);
      step(($urandom_range(0, 9) < 6), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 19) == 0));
    end
    en = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(20, 1'b1, 1'b1);
    check("sb_drained_rand", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset mid-operation with five entries buffered
    idle(2, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
    check("pre_reset_level", 32'(level), 32'd5);
    rx_in = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_rx_sync", 32'(rx_sync), 32'd1);
    check("arst_core_reset", 32'(core_reset), 32'd1);
    check("arst_overrun", 32'(overrun), 32'd0);
    model_q.delete();
    sb_q.delete();
    ov_model = 1'b0;
    cr_model = 1'b1;
    h1 = 1'b1;
    h2 = 1'b1;
    rx_in = 1'b1;
    #2;
    reset_n = 1'b1;
    idle(3, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    check("post_reset_data", 32'(m_data), 32'h5A);
    idle(2, 1'b1, 1'b1);
    check("sb_drained_final", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
